// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: load/store size encodings
// carried on func3, the memory-stage state type, and the alignment rule
// used when MISALIGN_TRAP_EN is defined.
package core_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // A halfword must sit on an even address and a word on a multiple of
   // four; bytes can never be misaligned.
   function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
      logic r;
      r = 1'b0;
      if ((f3 == F3_H) || (f3 == F3_HU)) begin
         r = off[0];
      end else if (f3 == F3_W) begin
         r = (off != 2'b00);
      end
      return r;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the memory stage. The store half replicates
// store data across lanes and builds byte strobes from the incoming
// instruction; the load half picks the addressed byte/halfword out of the
// returned bus word and sign- or zero-extends it using the latched size.
import core_pkg::*;

module lsu_align (
   input  logic [2:0]  i_st_func3,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   input  logic [2:0]  i_ld_func3,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
   assign w_half = i_rdata[{i_ld_off[1], 4'b0000} +: 16];

   // Store lanes: sub-word data is copied into every lane so the strobe
   // alone selects where it lands; anything not b/h is a full word.
   always_comb begin
      o_wdata = i_st_data;
      o_wstrb = 4'b1111;
      case (i_st_func3)
         F3_B: begin
            o_wdata = {4{i_st_data[7:0]}};
            o_wstrb = 4'b0001 << i_st_off;
         end
         F3_H: begin
            o_wdata = {2{i_st_data[15:0]}};
            o_wstrb = 4'b0011 << {i_st_off[1], 1'b0};
         end
         default: begin
         end
      endcase
   end

   // Load extract: signed sizes replicate the top bit, unsigned ones pad
   // with zeros, and word or unknown sizes return the raw bus word.
   always_comb begin
      o_ld_data = i_rdata;
      case (i_ld_func3)
         F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_ld_data = {24'd0, w_byte};
         F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_ld_data = {16'd0, w_half};
         default: o_ld_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory stage: passes ALU results through in one cycle, runs loads and
// stores over a req/ack bus with an optional ack timeout, and emits one
// writeback beat per accepted instruction.
// Optional build macro MISALIGN_TRAP_EN: misaligned h/w accesses skip the
// bus and pulse the extra 'misalign' output instead.
import core_pkg::*;

module mem_access #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] result_i,
   input  logic [4:0]  dest_i,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_dest,
   output logic [31:0] wb_data,
`ifdef MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic        bus_err
);

   localparam bit             TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_func3;
   logic [1:0]         r_off;
   logic [4:0]         r_dest;
   logic               r_isLoad;
   logic               r_busy;
   logic               r_memReq;
   logic               r_memWe;
   logic [31:0]        r_memAddr;
   logic [31:0]        r_memWdata;
   logic [3:0]         r_memWstrb;
   logic               r_wbValid;
   logic [4:0]         r_wbDest;
   logic [31:0]        r_wbData;
   logic               r_busErr;
`ifdef MISALIGN_TRAP_EN
   logic               r_misalign;
`endif

   logic [31:0]        w_wdata;
   logic [3:0]         w_wstrb;
   logic [31:0]        w_ldData;
   logic               w_memOp;
   logic               w_trap;

   assign w_memOp = is_load | is_store;

`ifdef MISALIGN_TRAP_EN
   assign w_trap   = isMisaligned(func3, addr[1:0]);
   assign misalign = r_misalign;
`else
   assign w_trap = 1'b0;
`endif

   lsu_align u_align (
      .i_st_func3 (func3),
      .i_st_off   (addr[1:0]),
      .i_st_data  (store_data),
      .o_wdata    (w_wdata),
      .o_wstrb    (w_wstrb),
      .i_ld_func3 (r_func3),
      .i_ld_off   (r_off),
      .i_rdata    (mem_rdata),
      .o_ld_data  (w_ldData)
   );

   assign busy      = r_busy;
   assign mem_req   = r_memReq;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;
   assign mem_wstrb = r_memWstrb;
   assign wb_valid  = r_wbValid;
   assign wb_dest   = r_wbDest;
   assign wb_data   = r_wbData;
   assign bus_err   = r_busErr;

   // Stage FSM: accept work in IDLE, hold the bus request in ACCESS until
   // ack or timeout, and drive the single-cycle writeback/error pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_func3    <= '0;
         r_off      <= '0;
         r_dest     <= '0;
         r_isLoad   <= 1'b0;
         r_busy     <= 1'b0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_memWstrb <= '0;
         r_wbValid  <= 1'b0;
         r_wbDest   <= '0;
         r_wbData   <= '0;
         r_busErr   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         r_misalign <= 1'b0;
`endif
      end else begin
         r_wbValid <= 1'b0;
         r_busErr  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         r_misalign <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_memOp && !w_trap) begin
                     r_state    <= ACCESS;
                     r_busy     <= 1'b1;
                     r_memReq   <= 1'b1;
                     r_memWe    <= ~is_load;
                     r_memAddr  <= {addr[31:2], 2'b00};
                     r_memWdata <= is_load ? 32'd0 : w_wdata;
                     r_memWstrb <= is_load ? 4'd0 : w_wstrb;
                     r_func3    <= func3;
                     r_off      <= addr[1:0];
                     r_dest     <= dest_i;
                     r_isLoad   <= is_load;
                     r_cnt      <= '0;
                  end else if (w_memOp) begin
                     r_wbValid <= 1'b1;
                     r_wbDest  <= 5'd0;
`ifdef MISALIGN_TRAP_EN
                     r_misalign <= 1'b1;
`endif
                  end else begin
                     r_wbValid <= 1'b1;
                     r_wbDest  <= dest_i;
                     r_wbData  <= result_i;
                  end
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
                  r_memReq   <= 1'b0;
                  r_memWe    <= 1'b0;
                  r_memWstrb <= 4'd0;
                  r_wbValid  <= 1'b1;
                  if (r_isLoad) begin
                     r_wbDest <= r_dest;
                     r_wbData <= w_ldData;
                  end else begin
                     r_wbDest <= 5'd0;
                  end
               end else if (TO_EN && (r_cnt == TO_LAST)) begin
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
                  r_memReq   <= 1'b0;
                  r_memWe    <= 1'b0;
                  r_memWstrb <= 4'd0;
                  r_busErr   <= 1'b1;
                  r_wbValid  <= 1'b1;
                  r_wbDest   <= 5'd0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the core, directly downstream of the execute stage.
- Consumes execute's result and destination, plus the load/store qualifiers.
- Performs data-memory loads and stores over a simple req/ack bus.
- Extracts and extends load data, and forwards a single writeback beat to the register-file write stage.
- Non-memory results pass through with one cycle of latency.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for mem_ack before aborting with bus_err. 0 = wait forever.
- CNT_W, 8: width of the wait counter. Must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  one clock; reset is synchronous and active-low. Name follows codebase convention; asserted when 0.
- in_valid  in  1  execute output is valid this cycle.
- is_load  in  1  instruction is a load.
- is_store  in  1  instruction is a store.
- func3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  effective address (execute result).
- store_data  in  32  rs2 value for stores.
- result_i  in  32  ALU/jump result for non-memory instructions.
- dest_i  in  5  destination register.
- busy  out  1  stage is stalled; upstream must hold its outputs.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0 on reads.
- mem_ack  in  1  bus completes this cycle; mem_rdata valid for reads.
- mem_rdata  in  32  read data.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_dest  out  5  writeback register; 0 = no write.
- wb_data  out  32  writeback value.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - All outputs 0: busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid, wb_dest, wb_data, bus_err.
  - Wait counter = 0.
  - Reset mid-transaction drops mem_req at that edge; the outstanding transaction is abandoned and no wb_valid is issued.
- States: IDLE, ACCESS.
- IDLE, in_valid and neither load nor store:
  - Next cycle: wb_valid=1, wb_dest=dest_i, wb_data=result_i.
  - Latency 1; throughput 1 per cycle.
- IDLE, in_valid and (is_load or is_store):
  - Next cycle: state=ACCESS; mem_req=1 and busy=1.
  - Latch addr, func3, dest_i, and lane data/strobe.
  - is_load has priority if both qualifiers are set.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until the ack edge.
  - busy=1, so in_valid is ignored.
  - The counter increments each cycle mem_ack=0.
- Ack (mem_ack=1 while mem_req=1; ack in the first ACCESS cycle is legal):
  - Next edge: mem_req=0, busy=0, state=IDLE, wb_valid=1.
  - Load: wb_dest=latched dest, wb_data=extracted rdata.
  - Store: wb_dest=0.
  - Minimum load/store latency is 2 cycles from in_valid to wb_valid.
  - mem_ack outside ACCESS is ignored.
- Timeout: TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack.
  - Next edge: mem_req=0, bus_err=1 for one cycle, wb_valid=1 with wb_dest=0, state=IDLE.
- Store lanes:
  - sb: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{sd[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - sw and unlisted func3: wdata=sd, wstrb=4'b1111.
- Load extract:
  - byte = rdata[8*addr[1:0]+:8].
  - half = rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw and unlisted func3 take the full word.
- Loads with dest 0 still perform the bus read; wb_dest=0.
- wb_valid, bus_err: single-cycle pulses; wb_dest/wb_data hold their last value otherwise.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Halfword accesses with addr[0]=1, and word accesses with addr[1:0]!=0, issue no bus request.
  - Next cycle: misalign=1 pulse (extra 1-bit output port, present only with the macro), wb_valid=1, wb_dest=0.
  - State stays IDLE.
- Undefined: no port; low address bits below the access size are ignored (access is forced aligned).

Decomposition:
- Shared package core_pkg:
  - func3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (IDLE, ACCESS).
- One sub-module, lsu_align: combinational store lane/strobe generation and load extract/extend, instantiated once.
- FSM, counter and registers stay in mem_access.

Test Plan:
- ALU pass-through: in_valid=1, result_i=32'h1234_5678, dest_i=5 → next cycle wb_valid=1, wb_dest=5, wb_data=32'h1234_5678, mem_req=0.
- lb sign-extend: addr=32'h103, func3=000, rdata=32'h80FF_FF00, ack on second ACCESS cycle → mem_addr=32'h100, wb_data=32'hFFFF_FF80, wb_valid 3 cycles after in_valid.
- sh: addr=32'h202, store_data=32'hAAAA_BEEF → mem_we=1, mem_wdata=32'hBEEF_BEEF, mem_wstrb=4'b1100; ack → wb_valid with wb_dest=0.
- Timeout: TIMEOUT=4, lw, never ack → mem_req high 4 cycles then 0, bus_err pulse, wb_dest=0, busy falls.
- Reset mid-access: reset=0 while mem_req=1 → next edge mem_req=0, busy=0, no wb_valid; a later ack is ignored.
- MISALIGN_TRAP_EN: lw at addr=32'h101 → no mem_req, misalign=1 for one cycle, wb_dest=0.
